vga_clksel_seq: RTL
===================

// Module: vga_clksel_seq
// PURPOSE
//  Sequences pixel-clock changes for the VGA output. Sits between the vgafb clksel CSR field and the pixel-clock mux.
//  Never switches the mux while the video pipeline runs: blank, hold pipeline reset, re-lock DCM, switch, settle, release.
//  Runs in sys_clk domain; all outputs registered.
// PARAMETERS
//  BLANK_CYCLES    1024   sys_clk cycles of blanking/reset before the mux moves
//  DCM_RST_CYCLES  8      width of dcm_rst pulse when target is 65 MHz
//  SETTLE_CYCLES   256    cycles after mux change before pipeline reset is released
//  TIMEOUT_CYCLES  65536  max wait for DCM lock (VGA_CLKSEL_TIMEOUT_EN only)
//  CNT_W           17     shared down-counter width; must hold max of above
// PORTS
//  sys_clk        in   1  system clock
//  sys_rst_n      in   1  async active-low reset
//  clksel_req     in   2  requested clock: 0=25 MHz, 1=50 MHz, 2/3=65 MHz
//  dcm_locked     in   1  DCM LOCKED, asynchronous; synchronised internally
//  clksel         out  2  select to pixel-clock mux (0/1/2 only)
//  dcm_rst        out  1  DCM reset pulse
//  vga_rst        out  1  hold reset for the vgafb pixel pipeline
//  vga_blank      out  1  force psave/blank on pads
//  busy           out  1  sequence in progress
//  lock_err       out  1  sticky: last 65 MHz switch timed out
// BEHAVIOUR
//  Reset values: clksel=0, dcm_rst=0, vga_rst=1, vga_blank=1, busy=1, lock_err=0; FSM enters SETTLE, cnt=SETTLE_CYCLES-1.
//  tgt = (clksel_req==3) ? 2 : clksel_req, sampled in IDLE and in RELEASE.
//  IDLE: vga_rst=0, vga_blank=0, busy=0. tgt!=clksel -> BLANK next cycle, latch tgt, cnt=BLANK_CYCLES-1.
//  BLANK: vga_rst=vga_blank=busy=1; cnt==0 -> (latched tgt==2 ? DCMRST : SWITCH).
//  DCMRST: dcm_rst=1 for DCM_RST_CYCLES cycles exactly, then WAITLOCK.
//  WAITLOCK: waits for synced dcm_locked=1 (2-FF sync, +2 cycles latency) -> SWITCH.
//  SWITCH: one cycle; clksel<=latched tgt; lock_err<=0 if tgt==2; cnt=SETTLE_CYCLES-1; -> SETTLE.
//  SETTLE: cnt==0 -> RELEASE.
//  RELEASE: one cycle; vga_rst/vga_blank deassert on the IDLE cycle following.
//   If a new tgt!=clksel is pending, go to BLANK directly (pipeline stays in reset; no release glitch).
//  clksel_req changes during a sequence are ignored until RELEASE; the last value wins.
//  clksel changes only in SWITCH, and only while vga_rst=1; glitch on the mux output is absorbed by the held pipeline.
//  Async reset mid-sequence: outputs return to reset values immediately. The mux drops to 25 MHz while blanked.
//  Counter arithmetic: unsigned down-count, loaded with N-1; zero-length parameters are illegal.
// CONFIGURATION
//  `VGA_CLKSEL_TIMEOUT_EN defined: WAITLOCK loads cnt=TIMEOUT_CYCLES-1 on entry.
//   On cnt==0 without lock: lock_err<=1, latched tgt<=0 (fallback to 25 MHz), -> SWITCH.
//  Undefined: WAITLOCK waits forever; lock_err is tied 0; TIMEOUT_CYCLES is unused.
// STRUCTURE
//  Package vga_clksel_pkg: CLKSEL_25=2'd0, CLKSEL_50=2'd1, CLKSEL_65=2'd2; state encoding
//   S_IDLE, S_BLANK, S_DCMRST, S_WAITLOCK, S_SWITCH, S_SETTLE, S_RELEASE.
//  One sub-module: vga_clksel_sync, a 2-FF synchroniser for dcm_locked, reset to 0.
//  Single shared down-counter; single FSM; no other hierarchy.
// TESTING (BLANK=4, DCM_RST=2, SETTLE=3, TIMEOUT=16)
//  1 Reset release, req=0: vga_rst=1 for 3 SETTLE + 1 RELEASE cycles, then 0; clksel stays 0; busy falls with vga_rst.
//  2 req 0->1: busy next cycle; clksel=1 exactly 4 cycles after BLANK entry; no dcm_rst; vga_rst low 3+1 cycles after SWITCH.
//  3 req 0->2, locked rises 5 cycles into WAITLOCK: dcm_rst high exactly 2 cycles; clksel=2 after sync latency; lock_err=0.
//  4 TIMEOUT_EN, req->2, locked stuck 0: after 16 WAITLOCK cycles lock_err=1, clksel=0, pipeline released.
//   Without the macro, still busy after 1000 cycles.
//  5 req 0->1, then 1->2 mid-SETTLE: clksel=1 first; RELEASE goes straight to BLANK with vga_rst never dropping; final clksel=2.
//  6 sys_rst_n pulsed low in WAITLOCK: dcm_rst=0, clksel=0, vga_rst=1 same cycle; full SETTLE sequence replays.
//   req=3 in IDLE with clksel=2: no sequence started.

Source files
------------

// File: rtl/vga_clksel_pkg.sv
// Shared constants, state encoding and request decoding for the VGA pixel-clock
// change sequencer.
package vga_clksel_pkg;

    localparam logic [1:0] CLKSEL_25 = 2'd0;
    localparam logic [1:0] CLKSEL_50 = 2'd1;
    localparam logic [1:0] CLKSEL_65 = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_DCMRST,
        S_WAITLOCK,
        S_SWITCH,
        S_SETTLE,
        S_RELEASE
    } state_t;

    // Request codes 2 and 3 both select the 65 MHz DCM output.
    function automatic logic [1:0] req_to_tgt(input logic [1:0] req);
        return (req == 2'd3) ? CLKSEL_65 : req;
    endfunction

endpackage

// File: rtl/vga_clksel_sync.sv
// Two-flop synchroniser that brings the asynchronous DCM LOCKED flag into the
// sys_clk domain; it resets to "not locked".
module vga_clksel_sync (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/vga_clksel_seq.sv
// Pixel-clock change sequencer: blanks and resets the video pipeline, re-locks the
// DCM for 65 MHz, moves the mux, settles, releases. Option: VGA_CLKSEL_TIMEOUT_EN.
module vga_clksel_seq
    import vga_clksel_pkg::*;
#(
    parameter int BLANK_CYCLES   = 1024,
    parameter int DCM_RST_CYCLES = 8,
    parameter int SETTLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_W          = 17
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] clksel_req,
    input  logic       dcm_locked,
    output logic [1:0] clksel,
    output logic       dcm_rst,
    output logic       vga_rst,
    output logic       vga_blank,
    output logic       busy,
    output logic       lock_err
);

    localparam int MAX_CYCLES_A = (BLANK_CYCLES > DCM_RST_CYCLES) ? BLANK_CYCLES : DCM_RST_CYCLES;
    localparam int MAX_CYCLES_B = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CYCLES   = (MAX_CYCLES_A > MAX_CYCLES_B) ? MAX_CYCLES_A : MAX_CYCLES_B;
    localparam int MIN_CYCLES_A = (BLANK_CYCLES < DCM_RST_CYCLES) ? BLANK_CYCLES : DCM_RST_CYCLES;
    localparam int MIN_CYCLES_B = (SETTLE_CYCLES < TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int MIN_CYCLES   = (MIN_CYCLES_A < MIN_CYCLES_B) ? MIN_CYCLES_A : MIN_CYCLES_B;
    localparam longint CNT_RANGE = longint'(1) << CNT_W;

    if (MIN_CYCLES < 1 || longint'(MAX_CYCLES) > CNT_RANGE) begin : g_bad_params
        $error("vga_clksel_seq: cycle counts must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] BLANK_LOAD   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCMRST_LOAD  = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
`ifdef VGA_CLKSEL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    logic lock_err_q;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       tgt_q;
    logic [1:0]       req_tgt;
    logic             cnt_zero;
    logic             locked_s;

    assign req_tgt  = req_to_tgt(clksel_req);
    assign cnt_zero = (cnt == '0);

    vga_clksel_sync u_lock_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .async_in  (dcm_locked),
        .sync_out  (locked_s)
    );

`ifdef VGA_CLKSEL_TIMEOUT_EN
    assign lock_err = lock_err_q;
`else
    assign lock_err = 1'b0;
`endif

    // NOTE: every output is assigned next to the state change that implies it, so
    // all outputs come straight from flops and the mux select never glitches.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_SETTLE;
            cnt       <= SETTLE_LOAD;
            tgt_q     <= CLKSEL_25;
            clksel    <= CLKSEL_25;
            dcm_rst   <= 1'b0;
            vga_rst   <= 1'b1;
            vga_blank <= 1'b1;
            busy      <= 1'b1;
`ifdef VGA_CLKSEL_TIMEOUT_EN
            lock_err_q <= 1'b0;
`endif
        end else begin
            if (!cnt_zero) cnt <= cnt - 1'b1;

            case (state)
                S_IDLE: begin
                    if (req_tgt != clksel) begin
                        tgt_q     <= req_tgt;
                        cnt       <= BLANK_LOAD;
                        state     <= S_BLANK;
                        vga_rst   <= 1'b1;
                        vga_blank <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_BLANK: begin
                    if (cnt_zero) begin
                        if (tgt_q == CLKSEL_65) begin
                            dcm_rst <= 1'b1;
                            cnt     <= DCMRST_LOAD;
                            state   <= S_DCMRST;
                        end else begin
                            state <= S_SWITCH;
                        end
                    end
                end
                S_DCMRST: begin
                    if (cnt_zero) begin
                        dcm_rst <= 1'b0;
                        state   <= S_WAITLOCK;
`ifdef VGA_CLKSEL_TIMEOUT_EN
                        cnt     <= TIMEOUT_LOAD;
`endif
                    end
                end
                S_WAITLOCK: begin
                    if (locked_s) begin
                        state <= S_SWITCH;
`ifdef VGA_CLKSEL_TIMEOUT_EN
                    end else if (cnt_zero) begin
                        // No lock in time: fall back to the always-available 25 MHz.
                        lock_err_q <= 1'b1;
                        tgt_q      <= CLKSEL_25;
                        state      <= S_SWITCH;
`endif
                    end
                end
                S_SWITCH: begin
                    clksel <= tgt_q;
`ifdef VGA_CLKSEL_TIMEOUT_EN
                    if (tgt_q == CLKSEL_65) lock_err_q <= 1'b0;
`endif
                    cnt    <= SETTLE_LOAD;
                    state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt_zero) state <= S_RELEASE;
                end
                S_RELEASE: begin
                    // A request that arrived mid-sequence restarts without releasing.
                    if (req_tgt != clksel) begin
                        tgt_q <= req_tgt;
                        cnt   <= BLANK_LOAD;
                        state <= S_BLANK;
                    end else begin
                        vga_rst   <= 1'b0;
                        vga_blank <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    cnt       <= SETTLE_LOAD;
                    dcm_rst   <= 1'b0;
                    vga_rst   <= 1'b1;
                    vga_blank <= 1'b1;
                    busy      <= 1'b1;
                    state     <= S_SETTLE;
                end
            endcase
        end
    end

endmodule
